// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the parametrised UART receiver.
// Optional build macro UART_RX_MAJORITY_EN (see uart_rx_bit_timer) uses maj3 below.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_CLEANUP   = 3'd5,
    ST_WAIT_HIGH = 3'd6
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // 2-of-3 vote used when majority sampling is built in
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: enable and serial line in, received word and status out.
// master drives the line and enable; slave is the receiver itself.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 i_Enable;
  logic                 i_Rx_Serial;
  logic                 o_Rx_DV;
  logic [DATA_BITS-1:0] o_Rx_Byte;
  logic                 o_Parity_Err;
  logic                 o_Frame_Err;
  logic                 o_Busy;

  modport master (
    output i_Enable,
    output i_Rx_Serial,
    input  o_Rx_DV,
    input  o_Rx_Byte,
    input  o_Parity_Err,
    input  o_Frame_Err,
    input  o_Busy
  );

  modport slave (
    input  i_Enable,
    input  i_Rx_Serial,
    output o_Rx_DV,
    output o_Rx_Byte,
    output o_Parity_Err,
    output o_Frame_Err,
    output o_Busy
  );
endinterface

// File: rtl/uart_rx_bit_timer.sv
// Baud counter producing the half-bit and full-bit sample strobes plus the sampled value.
// With UART_RX_MAJORITY_EN defined, strobes move one cycle later and carry a 2-of-3 vote.
module uart_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic rx_s,
  output logic bit_tick,
  output logic half_tick,
  output logic bit_val
);
  import uart_rx_pkg::*;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'((CLKS_PER_BIT - 1) / 2);

  logic [CNT_W-1:0] cnt;
  logic             at_last;
  logic             at_half;

  assign at_last = (cnt == LAST_CNT);
  assign at_half = (cnt == HALF_CNT);

  // Free-running bit counter, wraps at every bit boundary and is held at 0 while cleared
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (at_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist;
  logic       last_d;
  logic       half_d;

  // hist holds rx_s from the sample point and the cycle before it when the delayed strobe fires
  always_ff @(posedge clk) begin
    if (rst) begin
      hist   <= 2'b11;
      last_d <= 1'b0;
      half_d <= 1'b0;
    end else begin
      hist   <= {hist[0], rx_s};
      last_d <= at_last && !clear;
      half_d <= at_half && !clear;
    end
  end

  assign bit_tick  = last_d;
  assign half_tick = half_d;
  assign bit_val   = maj3(hist[1], hist[0], rx_s);
`else
  assign bit_tick  = at_last;
  assign half_tick = at_half;
  assign bit_val   = rx_s;
`endif

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, frame FSM, parity and framing checks.
// Build option UART_RX_MAJORITY_EN selects 3-sample majority voting in the bit timer.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input logic      i_Clock,
  input logic      i_Reset,
  uart_rx_if.slave bus
);
  import uart_rx_pkg::*;

  localparam int               IDX_W      = $clog2(DATA_BITS);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DATA_BITS - 1);
  localparam bit               PARITY_ON  = (PARITY_MODE != PAR_NONE);
  localparam bit               PARITY_ODD = (PARITY_MODE == PAR_ODD);

  rx_state_t            state;
  rx_state_t            next_state;
  logic                 sync1;
  logic                 sync2;
  logic                 rx_s;
  logic                 timer_clear;
  logic                 bit_tick;
  logic                 half_tick;
  logic                 bit_val;
  logic [DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]     bit_index;
  logic                 stop_index;
  logic                 par_err;
  logic                 frm_err;
  logic [DATA_BITS-1:0] byte_q;
  logic                 par_q;
  logic                 frm_q;
  logic                 last_data;
  logic                 last_stop;
  logic                 exp_parity;

  // Synchroniser flops idle at the line's high level so reset never looks like a start bit
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= bus.i_Rx_Serial;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  uart_rx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (i_Clock),
    .rst      (i_Reset),
    .clear    (timer_clear),
    .rx_s     (rx_s),
    .bit_tick (bit_tick),
    .half_tick(half_tick),
    .bit_val  (bit_val)
  );

  assign last_data  = (bit_index == LAST_IDX);
  assign last_stop  = (STOP_BITS == 1) ? 1'b1 : stop_index;
  assign exp_parity = (^shift) ^ PARITY_ODD;

  // Counter restarts on entering START and again at the centre of the start bit
  assign timer_clear = (state == ST_IDLE) || (next_state == ST_IDLE) ||
                       ((state == ST_START) && (next_state == ST_DATA));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (!bus.i_Enable) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (!rx_s) next_state = ST_START;
        ST_START:     if (half_tick) next_state = bit_val ? ST_IDLE : ST_DATA;
        ST_DATA:      if (bit_tick && last_data) next_state = PARITY_ON ? ST_PARITY : ST_STOP;
        ST_PARITY:    if (bit_tick) next_state = ST_STOP;
        ST_STOP:      if (bit_tick && last_stop) next_state = ST_CLEANUP;
        ST_CLEANUP:   next_state = (frm_q && !rx_s) ? ST_WAIT_HIGH : ST_IDLE;
        ST_WAIT_HIGH: if (rx_s) next_state = ST_IDLE;
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  // Frame datapath; the delivered word and flags load together on the edge into CLEANUP
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      shift      <= '0;
      bit_index  <= '0;
      stop_index <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
      byte_q     <= '0;
      par_q      <= 1'b0;
      frm_q      <= 1'b0;
    end else if (!bus.i_Enable || (state == ST_IDLE)) begin
      bit_index  <= '0;
      stop_index <= 1'b0;
      par_err    <= 1'b0;
      frm_err    <= 1'b0;
    end else begin
      case (state)
        ST_DATA: begin
          if (bit_tick) begin
            shift[bit_index] <= bit_val;
            bit_index        <= bit_index + 1'b1;
          end
        end
        ST_PARITY: begin
          if (bit_tick) par_err <= (bit_val != exp_parity);
        end
        ST_STOP: begin
          if (bit_tick) begin
            stop_index <= 1'b1;
            frm_err    <= frm_err | ~bit_val;
            if (last_stop) begin
              byte_q <= shift;
              par_q  <= PARITY_ON && par_err;
              frm_q  <= frm_err | ~bit_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.o_Rx_DV      = (state == ST_CLEANUP);
    bus.o_Busy       = (state != ST_IDLE);
    bus.o_Rx_Byte    = byte_q;
    bus.o_Parity_Err = par_q;
    bus.o_Frame_Err  = frm_q;
  end

endmodule
